// File: rtl/load_align_unit.sv
// Load-side data memory unit: word-aligned reads, lane extraction and sign/zero extension.
// Build option MISALIGNED_SPLIT_EN enables two-read handling of word-crossing loads.
module load_align_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ0, S_REQ1, S_DONE} state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_res_data;
  logic        r_res_err;
  logic        w_res_load;
  logic [31:0] w_res_data;
  logic        w_res_err;
  logic        w_bad;
  logic [31:0] w_word;

  function automatic logic f_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic f_cross(input logic [1:0] off, input logic [1:0] sz);
    case (sz)
      2'b01:   return off == 2'b11;
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // w holds {hi,lo}; the addressed bytes are shifted down to lane 0
  function automatic logic [31:0] f_extract(input logic [63:0] w, input logic [1:0] off,
                                            input logic [2:0] f3);
    logic [31:0] x;
    x = 32'(w >> {off, 3'b000});
    case (f3)
      3'b000:  return {{24{x[7]}}, x[7:0]};
      3'b001:  return {{16{x[15]}}, x[15:0]};
      3'b010:  return x;
      3'b100:  return {24'h0, x[7:0]};
      3'b101:  return {16'h0, x[15:0]};
      default: return 32'h0;
    endcase
  endfunction

`ifdef MISALIGNED_SPLIT_EN
  logic [31:0] r_lo;
  logic        w_lo_load;
  assign w_bad = f_illegal(ld_funct3);
`else
  assign w_bad = f_illegal(ld_funct3) || f_cross(ld_addr[1:0], ld_funct3[1:0]);
`endif

  assign w_word    = {r_addr[31:2], 2'b00};
  assign ld_ready  = (r_state == S_IDLE);
  assign mem_req   = (r_state == S_REQ0) || (r_state == S_REQ1);
  assign res_valid = (r_state == S_DONE);
  assign res_data  = r_res_data;
  assign res_err   = r_res_err;

  always_comb begin
    mem_addr = 32'h0;
    case (r_state)
      S_REQ0:  mem_addr = w_word;
`ifdef MISALIGNED_SPLIT_EN
      S_REQ1:  mem_addr = w_word + 32'd4;
`endif
      default: mem_addr = 32'h0;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_res_load = 1'b0;
    w_res_data = 32'h0;
    w_res_err  = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    w_lo_load  = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (ld_valid) begin
          if (w_bad) begin
            w_next     = S_DONE;
            w_res_load = 1'b1;
            w_res_err  = 1'b1;
          end else begin
            w_next = S_REQ0;
          end
        end
      end
      S_REQ0: begin
        if (mem_ack) begin
`ifdef MISALIGNED_SPLIT_EN
          if (f_cross(r_addr[1:0], r_funct3[1:0])) begin
            w_next    = S_REQ1;
            w_lo_load = 1'b1;
          end else begin
            w_next     = S_DONE;
            w_res_load = 1'b1;
            w_res_data = f_extract({32'h0, mem_rdata}, r_addr[1:0], r_funct3);
          end
`else
          w_next     = S_DONE;
          w_res_load = 1'b1;
          w_res_data = f_extract({32'h0, mem_rdata}, r_addr[1:0], r_funct3);
`endif
        end
      end
      S_REQ1: begin
`ifdef MISALIGNED_SPLIT_EN
        // high word arrives on mem_rdata; it is consumed directly, never stored
        if (mem_ack) begin
          w_next     = S_DONE;
          w_res_load = 1'b1;
          w_res_data = f_extract({mem_rdata, r_lo}, r_addr[1:0], r_funct3);
        end
`else
        w_next = S_IDLE;
`endif
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr     <= 32'h0;
      r_funct3   <= 3'b000;
      r_res_data <= 32'h0;
      r_res_err  <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      r_lo       <= 32'h0;
`endif
    end else begin
      if (ld_valid && ld_ready) begin
        r_addr   <= ld_addr;
        r_funct3 <= ld_funct3;
      end
`ifdef MISALIGNED_SPLIT_EN
      if (w_lo_load) r_lo <= mem_rdata;
`endif
      if (w_res_load) begin
        r_res_data <= w_res_data;
        r_res_err  <= w_res_err;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: directed vector table, reset/wrap sequences and random loads
// against a byte-level reference model. Honours MISALIGNED_SPLIT_EN like the design.
module tb_load_align_unit;
`ifdef MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [31:0] ld_addr = 32'h0;
  logic [2:0]  ld_funct3 = 3'b000;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_err;

  int checks = 0;
  int errors = 0;
  int ack_delay = 0;
  bit spur = 1'b0;
  int wait_cnt = 0;
  int req_cycles = 0;
  logic [31:0] addr_q[$];
  logic [31:0] mem_ov [logic [31:0]];

  load_align_unit dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memrd(input logic [31:0] wa);
    if (mem_ov.exists(wa)) return mem_ov[wa];
    return (wa * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // memory responder: ack after ack_delay wait cycles; optional stray acks while idle
  always @(negedge clk) begin
    if (mem_req) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = memrd(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        wait_cnt  = wait_cnt + 1;
      end
    end else begin
      wait_cnt  = 0;
      mem_ack   = spur && ($urandom_range(0, 1) == 1);
      mem_rdata = $urandom;
    end
  end

  always @(posedge clk) begin
    if (mem_req) req_cycles = req_cycles + 1;
    if (mem_req && mem_ack) addr_q.push_back(mem_addr);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // reference: assemble the accessed bytes one by one from memory, then extend
  function automatic void ref_load(input logic [31:0] a, input logic [2:0] f3,
                                   output logic [31:0] d, output logic e, output int nw);
    int sz;
    logic [31:0] ba, v;
    logic [7:0] b;
    d = 32'h0; e = 1'b0; nw = 0;
    if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) begin e = 1'b1; return; end
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    nw = (int'(a[1:0]) + sz > 4) ? 2 : 1;
    if (nw == 2 && !SPLIT) begin e = 1'b1; nw = 0; return; end
    v = 32'h0;
    for (int i = 0; i < sz; i++) begin
      ba = a + 32'(i);
      b  = 8'(memrd({ba[31:2], 2'b00}) >> (8 * int'(ba[1:0])));
      v  = v | (32'(b) << (8 * i));
    end
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~((32'h1 << (8 * sz)) - 32'h1);
    d = v;
  endfunction

  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input int dly,
                          input logic [31:0] exp_d, input logic exp_e, input bit hold,
                          input string nm);
    logic [31:0] md, wa;
    logic me;
    int nw, n, exp_lat;
    bit got;
    ref_load(a, f3, md, me, nw);
    exp_lat   = 1 + nw * (1 + dly);
    ack_delay = dly;
    @(negedge clk);
    chk({nm, " ready"}, 32'(ld_ready), 32'd1);
    addr_q.delete();
    req_cycles = 0;
    ld_valid = 1'b1; ld_addr = a; ld_funct3 = f3;
    @(posedge clk); #1;
    if (hold) begin
      ld_addr = $urandom; ld_funct3 = 3'($urandom);
    end else begin
      ld_valid = 1'b0;
    end
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (res_valid) got = 1'b1;
    end
    ld_valid = 1'b0;
    chk({nm, " res_valid seen"}, 32'(got), 32'd1);
    chk({nm, " latency"}, 32'(n), 32'(exp_lat));
    chk({nm, " res_data"}, res_data, exp_d);
    chk({nm, " res_err"}, 32'(res_err), 32'(exp_e));
    chk({nm, " req cycles"}, 32'(req_cycles), 32'(nw * (1 + dly)));
    chk({nm, " req count"}, 32'(addr_q.size()), 32'(nw));
    wa = {a[31:2], 2'b00};
    for (int i = 0; i < nw && i < addr_q.size(); i++)
      chk({nm, " mem_addr"}, addr_q[i], wa + 32'(4 * i));
    @(negedge clk);
    chk({nm, " pulse end"}, 32'(res_valid), 32'd0);
    chk({nm, " back idle"}, {30'h0, ld_ready, mem_req}, 32'h2);
    chk({nm, " res_data hold"}, res_data, exp_d);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [2:0]  f3;
    int          dly;
    logic [31:0] d;
    logic        e;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[$];
    logic [31:0] md, ra;
    logic me;
    int nw, vcnt;
    logic [2:0] rf;

    mem_ov[32'h100] = 32'hDEADBEEF;
    mem_ov[32'h200] = 32'h80FF1234;
    mem_ov[32'h300] = 32'h44332211;
    mem_ov[32'h304] = 32'h88776655;

    tv.push_back('{32'h100, 3'b010, 0, 32'hDEADBEEF, 1'b0});
    tv.push_back('{32'h100, 3'b010, 2, 32'hDEADBEEF, 1'b0});
    tv.push_back('{32'h203, 3'b000, 0, 32'hFFFFFF80, 1'b0});
    tv.push_back('{32'h203, 3'b100, 1, 32'h00000080, 1'b0});
    tv.push_back('{32'h201, 3'b001, 0, 32'hFFFFFF12, 1'b0});
    tv.push_back('{32'h202, 3'b101, 0, 32'h000080FF, 1'b0});
    tv.push_back('{32'h200, 3'b000, 0, 32'h00000034, 1'b0});
    tv.push_back('{32'h200, 3'b001, 0, 32'h00001234, 1'b0});
    tv.push_back('{32'h301, 3'b001, 0, 32'h00003322, 1'b0});
    tv.push_back('{32'h100, 3'b011, 0, 32'h00000000, 1'b1});
    tv.push_back('{32'h203, 3'b100, 0, 32'h00000080, 1'b0});
    tv.push_back('{32'h300, 3'b110, 0, 32'h00000000, 1'b1});
    if (SPLIT) begin
      tv.push_back('{32'h302, 3'b010, 0, 32'h66554433, 1'b0});
      tv.push_back('{32'h303, 3'b001, 2, 32'h00005544, 1'b0});
    end else begin
      tv.push_back('{32'h302, 3'b010, 0, 32'h00000000, 1'b1});
      tv.push_back('{32'h303, 3'b001, 0, 32'h00000000, 1'b1});
    end

    #12;
    chk("reset ld_ready", 32'(ld_ready), 32'd1);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset res_valid", 32'(res_valid), 32'd0);
    chk("reset res_data", res_data, 32'h0);
    chk("reset res_err", 32'(res_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vcnt = 0;
    foreach (tv[i]) begin
      run_load(tv[i].a, tv[i].f3, tv[i].dly, tv[i].d, tv[i].e, 1'b0, $sformatf("vec%0d", vcnt));
      vcnt++;
    end

    // address wrap at the top of memory
    ref_load(32'hFFFFFFFF, 3'b001, md, me, nw);
    run_load(32'hFFFFFFFF, 3'b001, 1, md, me, 1'b0, "wrap LH");

    // reset while waiting for ack in REQ0
    ack_delay = 1000;
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = 32'h100; ld_funct3 = 3'b010;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("stall mem_req", 32'(mem_req), 32'd1);
    chk("stall mem_addr", mem_addr, 32'h100);
    #2 rst = 1'b1;
    #1;
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst ld_ready", 32'(ld_ready), 32'd1);
    chk("midrst res_data", res_data, 32'h0);
    chk("midrst res_err", 32'(res_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    nw = 0;
    repeat (5) begin
      @(negedge clk);
      if (res_valid) nw++;
    end
    chk("midrst no res_valid", 32'(nw), 32'd0);
    run_load(32'h100, 3'b010, 0, 32'hDEADBEEF, 1'b0, 1'b0, "post-reset LW");

    // random loads with random waits, stray acks and ld_valid held while busy
    for (int k = 0; k < 150; k++) begin
      ra = ($urandom_range(0, 3) == 0) ? (32'h300 + 32'($urandom_range(0, 7))) : $urandom;
      rf = 3'($urandom_range(0, 7));
      spur = ($urandom_range(0, 1) == 1);
      ref_load(ra, rf, md, me, nw);
      run_load(ra, rf, $urandom_range(0, 3), md, me, ($urandom_range(0, 1) == 1),
               $sformatf("rnd%0d", k));
    end
    spur = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
